// File: rtl/despacho_param.sv
// despacho_param: parametrised Tomasulo dispatch stage between the instruction
// queue and the ADD/LOAD reservation-station banks.
// Optional feature macro: DESPACHO_CDB_BYPASS_EN (CDB forwarding into operands
// in the accept cycle). Default build ignores the CDB inputs.
module despacho_param #(
  parameter  int unsigned DATA_W      = 16,
  parameter  int unsigned N_ADD       = 2,
  parameter  int unsigned N_LOAD      = 2,
  parameter  int unsigned STALL_CNT_W = 8,
  localparam int unsigned TAG_W       = $clog2(N_ADD + N_LOAD + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [15:0]            Instr,
  input  logic                   Instr_valid,
  output logic                   Instr_ready,
  input  logic [8*TAG_W-1:0]     Rs_Qi,
  input  logic [8*DATA_W-1:0]    Rs_Qi_data,
  input  logic [N_ADD-1:0]       Busy_ADD,
  input  logic [N_LOAD-1:0]      Busy_LOAD,
  input  logic                   CDB_valid,
  input  logic [TAG_W-1:0]       CDB_tag,
  input  logic [DATA_W-1:0]      CDB_data,
  output logic [DATA_W-1:0]      Vj,
  output logic [DATA_W-1:0]      Vk,
  output logic [TAG_W-1:0]       Qj,
  output logic [TAG_W-1:0]       Qk,
  output logic [6:0]             A,
  output logic [2:0]             Op,
  output logic [N_ADD-1:0]       Enable_ADD,
  output logic [N_LOAD-1:0]      Enable_LOAD,
  output logic                   R_enable_despacho,
  output logic [2:0]             R_target_despacho,
  output logic [TAG_W-1:0]       R_tag_despacho,
  output logic [STALL_CNT_W-1:0] Stall_count
);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;

  // "no value" marker placed in V when the operand is still being produced
  localparam logic [DATA_W-1:0] SEM_VALOR = DATA_W'(16'hFFF0);
  localparam logic [6:0]        A_RST     = 7'h70;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t state, state_nxt;

  logic [2:0] op, ri, rj, rk, src_k;
  logic       is_add, is_ld, is_st, is_mem, writes_reg, accept;

  logic [N_ADD-1:0]  free_add, sel_add;
  logic [N_LOAD-1:0] free_load, sel_load;
  logic [TAG_W-1:0]  tag_add, tag_load;

  logic [TAG_W-1:0]  reg_q [8];
  logic [DATA_W-1:0] reg_d [8];

  logic              byp_j, byp_k;
  logic [DATA_W-1:0] res_vj, res_vk;
  logic [TAG_W-1:0]  res_qj, res_qk;

  assign op = Instr[15:13];
  assign ri = Instr[12:10];
  assign rj = Instr[9:7];
  assign rk = Instr[6:4];

  // Opcode class decode; unknown opcodes fall through as NOP
  always_comb begin
    is_add     = (op == OP_ADD) || (op == OP_SUB);
    is_ld      = (op == OP_LD);
    is_st      = (op == OP_ST);
    is_mem     = is_ld || is_st;
    writes_reg = is_add || is_ld;
    src_k      = is_st ? ri : rk;
  end

  // Lowest-index free station per bank; last cycle's enables mask the Busy lag
  always_comb begin
    free_add  = ~Busy_ADD & ~Enable_ADD;
    free_load = ~Busy_LOAD & ~Enable_LOAD;
    sel_add   = '0;
    sel_load  = '0;
    tag_add   = '0;
    tag_load  = '0;
    for (int k = N_ADD - 1; k >= 0; k--) begin
      if (free_add[k]) begin
        sel_add = N_ADD'(1) << k;
        tag_add = TAG_W'(k + 1);
      end
    end
    for (int k = N_LOAD - 1; k >= 0; k--) begin
      if (free_load[k]) begin
        sel_load = N_LOAD'(1) << k;
        tag_load = TAG_W'(N_ADD + 1 + k);
      end
    end
  end

  // Queue handshake: NOP always ready, otherwise needs a free station
  always_comb begin
    if (is_add)      Instr_ready = |free_add;
    else if (is_mem) Instr_ready = |free_load;
    else             Instr_ready = 1'b1;
  end

  assign accept = Instr_valid && Instr_ready;

  // Unpack the register status table
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      reg_q[r] = Rs_Qi[r*TAG_W +: TAG_W];
      reg_d[r] = Rs_Qi_data[r*DATA_W +: DATA_W];
    end
  end

  // Operand resolution; the previous dispatch's tag overrides stale status
  always_comb begin
    byp_j = R_enable_despacho && (R_target_despacho == rj);
    byp_k = R_enable_despacho && (R_target_despacho == src_k);

    if (byp_j) begin
      res_vj = SEM_VALOR;
      res_qj = R_tag_despacho;
    end else if (reg_q[rj] != '0) begin
      res_vj = SEM_VALOR;
      res_qj = reg_q[rj];
    end else begin
      res_vj = reg_d[rj];
      res_qj = '0;
    end

    if (is_ld) begin
      res_vk = SEM_VALOR;
      res_qk = '0;
    end else if (byp_k) begin
      res_vk = SEM_VALOR;
      res_qk = R_tag_despacho;
    end else if (reg_q[src_k] != '0) begin
      res_vk = SEM_VALOR;
      res_qk = reg_q[src_k];
    end else begin
      res_vk = reg_d[src_k];
      res_qk = '0;
    end

`ifdef DESPACHO_CDB_BYPASS_EN
    if (CDB_valid && (res_qj != '0) && (CDB_tag == res_qj)) begin
      res_vj = CDB_data;
      res_qj = '0;
    end
    if (CDB_valid && (res_qk != '0) && (CDB_tag == res_qk)) begin
      res_vk = CDB_data;
      res_qk = '0;
    end
`endif
  end

`ifndef DESPACHO_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{CDB_valid, CDB_tag, CDB_data};
`endif

  // Stall FSM next state: stalled while a valid head cannot be accepted
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (Instr_valid && !Instr_ready) state_nxt = STALL;
      STALL: if (accept || !Instr_valid)      state_nxt = RUN;
    endcase
  end

  // State, stall counter and registered dispatch outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state             <= RUN;
      Stall_count       <= '0;
      Vj                <= SEM_VALOR;
      Vk                <= SEM_VALOR;
      Qj                <= '0;
      Qk                <= '0;
      A                 <= A_RST;
      Op                <= '0;
      Enable_ADD        <= '0;
      Enable_LOAD       <= '0;
      R_enable_despacho <= 1'b0;
      R_target_despacho <= '0;
      R_tag_despacho    <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == STALL) && !(&Stall_count)) begin
        Stall_count <= Stall_count + STALL_CNT_W'(1);
      end

      Enable_ADD        <= (accept && is_add) ? sel_add : '0;
      Enable_LOAD       <= (accept && is_mem) ? sel_load : '0;
      R_enable_despacho <= accept && writes_reg;

      if (accept && (is_add || is_mem)) begin
        Vj <= res_vj;
        Qj <= res_qj;
        Vk <= res_vk;
        Qk <= res_qk;
        Op <= op;
        if (is_mem) A <= Instr[6:0];
      end

      if (accept && writes_reg) begin
        R_target_despacho <= ri;
        R_tag_despacho    <= is_add ? tag_add : tag_load;
      end
    end
  end

endmodule

// File: tb/tb_despacho_param.sv
// tb_despacho_param: directed vector table plus hand-written corner sequences
// for despacho_param at default parameters.
module tb_despacho_param;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned N_ADD       = 2;
  localparam int unsigned N_LOAD      = 2;
  localparam int unsigned STALL_CNT_W = 8;
  localparam int unsigned TAG_W       = 3;

  localparam logic [15:0] F = 16'hFFF0;
  localparam logic [127:0] RS_DATA = {16'h0077, 16'h0066, 16'h0055, 16'h0044,
                                      16'h0007, 16'h0005, 16'h0011, 16'h0000};

`ifdef DESPACHO_CDB_BYPASS_EN
  localparam logic [15:0] V9_VJ = 16'h0AAA;
  localparam logic [2:0]  V9_QJ = 3'd0;
`else
  localparam logic [15:0] V9_VJ = 16'hFFF0;
  localparam logic [2:0]  V9_QJ = 3'd2;
`endif

  logic                   Clock, Reset_n;
  logic [15:0]            Instr;
  logic                   Instr_valid, Instr_ready;
  logic [8*TAG_W-1:0]     Rs_Qi;
  logic [8*DATA_W-1:0]    Rs_Qi_data;
  logic [N_ADD-1:0]       Busy_ADD;
  logic [N_LOAD-1:0]      Busy_LOAD;
  logic                   CDB_valid;
  logic [TAG_W-1:0]       CDB_tag;
  logic [DATA_W-1:0]      CDB_data;
  logic [DATA_W-1:0]      Vj, Vk;
  logic [TAG_W-1:0]       Qj, Qk;
  logic [6:0]             A;
  logic [2:0]             Op;
  logic [N_ADD-1:0]       Enable_ADD;
  logic [N_LOAD-1:0]      Enable_LOAD;
  logic                   R_enable_despacho;
  logic [2:0]             R_target_despacho;
  logic [TAG_W-1:0]       R_tag_despacho;
  logic [STALL_CNT_W-1:0] Stall_count;

  despacho_param #(
    .DATA_W(DATA_W), .N_ADD(N_ADD), .N_LOAD(N_LOAD), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Instr(Instr), .Instr_valid(Instr_valid),
    .Instr_ready(Instr_ready), .Rs_Qi(Rs_Qi), .Rs_Qi_data(Rs_Qi_data),
    .Busy_ADD(Busy_ADD), .Busy_LOAD(Busy_LOAD), .CDB_valid(CDB_valid),
    .CDB_tag(CDB_tag), .CDB_data(CDB_data), .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk),
    .A(A), .Op(Op), .Enable_ADD(Enable_ADD), .Enable_LOAD(Enable_LOAD),
    .R_enable_despacho(R_enable_despacho), .R_target_despacho(R_target_despacho),
    .R_tag_despacho(R_tag_despacho), .Stall_count(Stall_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [23:0] qi;
    logic [1:0]  b_add;
    logic [1:0]  b_load;
    logic        cdb_v;
    logic        rdy;
    logic [1:0]  e_add;
    logic [1:0]  e_load;
    logic        ren;
    logic [2:0]  rtgt;
    logic [2:0]  rtag;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    logic [6:0]  a;
    logic [2:0]  op;
    logic [7:0]  stall;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  vec_t cur;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, " Vj"}, 32'(Vj), 32'(F));
    chk({t, " Vk"}, 32'(Vk), 32'(F));
    chk({t, " Qj"}, 32'(Qj), 32'd0);
    chk({t, " Qk"}, 32'(Qk), 32'd0);
    chk({t, " A"}, 32'(A), 32'h70);
    chk({t, " Op"}, 32'(Op), 32'd0);
    chk({t, " Enable_ADD"}, 32'(Enable_ADD), 32'd0);
    chk({t, " Enable_LOAD"}, 32'(Enable_LOAD), 32'd0);
    chk({t, " R_enable"}, 32'(R_enable_despacho), 32'd0);
    chk({t, " R_target"}, 32'(R_target_despacho), 32'd0);
    chk({t, " R_tag"}, 32'(R_tag_despacho), 32'd0);
    chk({t, " Stall_count"}, 32'(Stall_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset_n     = 1'b0;
    Instr       = '0;
    Instr_valid = 1'b0;
    Rs_Qi       = '0;
    Rs_Qi_data  = RS_DATA;
    Busy_ADD    = '0;
    Busy_LOAD   = '0;
    CDB_valid   = 1'b0;
    CDB_tag     = 3'd2;
    CDB_data    = 16'h0AAA;

    //            instr    vld  qi          bA     bL     cdb   rdy   eA     eL     ren   tgt   tag   vj        vk        qj    qk    a      op    stall
    vecs[0]  = '{16'h4530, 1'b1, 24'h000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1, 3'd1, 16'h0005, 16'h0007, 3'd0, 3'd0, 7'h70, 3'd2, 8'd0};
    vecs[1]  = '{16'h7090, 1'b1, 24'h000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd0};
    vecs[2]  = '{16'h0000, 1'b1, 24'h000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd0};
    vecs[3]  = '{16'h4530, 1'b0, 24'h000000, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd0};
    vecs[4]  = '{16'h4530, 1'b1, 24'h000000, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd1};
    vecs[5]  = '{16'h4530, 1'b1, 24'h000000, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd2};
    vecs[6]  = '{16'h4530, 1'b1, 24'h000000, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd4, 3'd2, F,        F,        3'd1, 3'd1, 7'h70, 3'd3, 8'd3};
    vecs[7]  = '{16'h4530, 1'b1, 24'h000000, 2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1, 3'd1, 16'h0005, 16'h0007, 3'd0, 3'd0, 7'h70, 3'd2, 8'd3};
    vecs[8]  = '{16'hB412, 1'b1, 24'h018000, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'd1, 3'd1, 16'h0000, F,        3'd0, 3'd3, 7'h12, 3'd5, 8'd3};
    vecs[9]  = '{16'h9905, 1'b1, 24'h000080, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 3'd6, 3'd4, V9_VJ,    F,        V9_QJ, 3'd0, 7'h05, 3'd4, 8'd3};
    vecs[10] = '{16'h5F60, 1'b1, 24'h000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 3'd7, 3'd1, F,        F,        3'd4, 3'd4, 7'h05, 3'd2, 8'd3};
    vecs[11] = '{16'hE000, 1'b1, 24'h000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'd7, 3'd1, F,        F,        3'd4, 3'd4, 7'h05, 3'd2, 8'd3};
    vecs[12] = '{16'h9905, 1'b1, 24'h000000, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd7, 3'd1, F,        F,        3'd4, 3'd4, 7'h05, 3'd2, 8'd4};
    vecs[13] = '{16'h9905, 1'b0, 24'h000000, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd7, 3'd1, F,        F,        3'd4, 3'd4, 7'h05, 3'd2, 8'd4};

    #12;
    chk_reset("por");
    @(negedge Clock);
    Reset_n = 1'b1;

    // Table-driven sequence; state carries from one vector to the next
    for (int i = 0; i < NVEC; i++) begin
      cur = vecs[i];
      @(negedge Clock);
      Instr       = cur.instr;
      Instr_valid = cur.valid;
      Rs_Qi       = cur.qi;
      Busy_ADD    = cur.b_add;
      Busy_LOAD   = cur.b_load;
      CDB_valid   = cur.cdb_v;
      #1;
      chk($sformatf("v%0d Instr_ready", i), 32'(Instr_ready), 32'(cur.rdy));
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d Enable_ADD", i), 32'(Enable_ADD), 32'(cur.e_add));
      chk($sformatf("v%0d Enable_LOAD", i), 32'(Enable_LOAD), 32'(cur.e_load));
      chk($sformatf("v%0d R_enable", i), 32'(R_enable_despacho), 32'(cur.ren));
      chk($sformatf("v%0d R_target", i), 32'(R_target_despacho), 32'(cur.rtgt));
      chk($sformatf("v%0d R_tag", i), 32'(R_tag_despacho), 32'(cur.rtag));
      chk($sformatf("v%0d Vj", i), 32'(Vj), 32'(cur.vj));
      chk($sformatf("v%0d Vk", i), 32'(Vk), 32'(cur.vk));
      chk($sformatf("v%0d Qj", i), 32'(Qj), 32'(cur.qj));
      chk($sformatf("v%0d Qk", i), 32'(Qk), 32'(cur.qk));
      chk($sformatf("v%0d A", i), 32'(A), 32'(cur.a));
      chk($sformatf("v%0d Op", i), 32'(Op), 32'(cur.op));
      chk($sformatf("v%0d Stall_count", i), 32'(Stall_count), 32'(cur.stall));
    end

    // Stall counter saturation: 300 stalled cycles on top of the existing 4
    @(negedge Clock);
    Instr       = 16'h4530;
    Instr_valid = 1'b1;
    Rs_Qi       = '0;
    Busy_ADD    = 2'b11;
    Busy_LOAD   = 2'b00;
    CDB_valid   = 1'b0;
    repeat (300) @(posedge Clock);
    #1;
    chk("sat Stall_count", 32'(Stall_count), 32'd255);
    chk("sat Instr_ready", 32'(Instr_ready), 32'd0);
    chk("sat Enable_ADD", 32'(Enable_ADD), 32'd0);

    // Reset in the middle of an issue pulse discards it
    @(negedge Clock);
    Busy_ADD = 2'b00;
    @(posedge Clock);
    #1;
    chk("mid Enable_ADD pre", 32'(Enable_ADD), 32'd1);
    chk("mid Stall_count pre", 32'(Stall_count), 32'd255);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset("mid");
    @(negedge Clock);
    Instr_valid = 1'b0;
    Reset_n     = 1'b1;
    @(posedge Clock);
    #1;
    chk("post Enable_ADD", 32'(Enable_ADD), 32'd0);
    chk("post R_enable", 32'(R_enable_despacho), 32'd0);
    chk("post Stall_count", 32'(Stall_count), 32'd0);
    @(posedge Clock);
    #1;
    chk("post2 Enable_ADD", 32'(Enable_ADD), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/despacho_param.md
Name: despacho_param

Overview:
- Parametrised successor of the Tomasulo dispatch unit; sits between the instruction queue and the ADD/LOAD reservation-station banks.
- Each cycle it decodes one queued 16-bit instruction and resolves its operands (V/Q) from the register status table.
- It selects the lowest-index free station of the required class, tags the destination register, and handshakes with the queue.
- Adds over the previous generation: N-way station banks, a ready/valid queue handshake, back-to-back hazard bypass, and a stall FSM with a stall counter.

Parameters:
- DATA_W, 16, operand/register data width.
- N_ADD, 2, number of ADD/SUB reservation stations (1..6).
- N_LOAD, 2, number of LD/ST reservation stations (1..6).
- STALL_CNT_W, 8, width of the saturating stall counter.
- Derived (localparam, not overridable): TAG_W = clog2(N_ADD+N_LOAD+1).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Instr  in  16  head of queue: op[15:13], Ri[12:10], Rj[9:7], Rk[6:4], A[6:0].
- Instr_valid  in  1  queue head valid.
- Instr_ready  out  1  combinational; the instruction is consumed on a cycle with Instr_valid && Instr_ready.
- Rs_Qi  in  8*TAG_W  per-register producer tag; 0 means the register is free.
- Rs_Qi_data  in  8*DATA_W  per-register value.
- Busy_ADD  in  N_ADD  station busy flags.
- Busy_LOAD  in  N_LOAD  station busy flags.
- CDB_valid  in  1  common data bus broadcast valid (used only with the optional feature).
- CDB_tag  in  TAG_W  broadcast tag.
- CDB_data  in  DATA_W  broadcast value.
- Vj, Vk  out  DATA_W  operand values.
- Qj, Qk  out  TAG_W  operand producer tags.
- A  out  7  immediate/address.
- Op  out  3  opcode delivered to the target station.
- Enable_ADD  out  N_ADD  one-hot load pulse into an ADD station.
- Enable_LOAD  out  N_LOAD  one-hot load pulse into a LOAD station.
- R_enable_despacho  out  1  register-status write enable.
- R_target_despacho  out  3  destination register.
- R_tag_despacho  out  TAG_W  tag written to the register status.
- Stall_count  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- Opcodes: NOP=0, ADD=2, SUB=3, LD=4, ST=5; any other opcode is treated as NOP.
- Tag map: 0 = free; ADD station k maps to k+1; LOAD station k maps to N_ADD+1+k.
- Reset (Reset_n low, asynchronous), all outputs take these values:
  - Vj = Vk = 16'hFFF0 pattern, zero-extended/truncated to DATA_W.
  - Qj = Qk = 0; A = 7'h70; Op = 0.
  - Enables = 0; R_enable_despacho = 0; R_target_despacho = 0; R_tag_despacho = 0.
  - Stall_count = 0; FSM = RUN; pending mask cleared.
- Registered outputs, latency 1: an instruction accepted at edge n drives its outputs during cycle n+1.
- Enable_* and R_enable_despacho are single-cycle pulses; they drop to 0 on any cycle without an accept.
- Free-station vector = ~Busy & ~pending. pending = the one-hot enabled last cycle, covering the one-cycle Busy lag; pending clears after one cycle.
- Instr_ready rules:
  - NOP: always ready.
  - ADD/SUB: ready iff some ADD station is free.
  - LD/ST: ready iff some LOAD station is free.
  - Instr_ready is independent of Instr_valid.
- Selection: lowest-index free station of the required class.
- Operand resolution:
  - Rj always drives Vj/Qj.
  - ADD/SUB: Rk drives Vk/Qk.
  - ST: Ri drives Vk/Qk.
  - LD: Vk/Qk take the sem-valor values.
  - A = Instr[6:0] for LD/ST only; otherwise A holds its previous value.
  - A free source gives V = data, Q = 0; a busy source gives V = sem-valor, Q = tag.
- Back-to-back bypass: if a source register equals the R_target_despacho accepted in the previous cycle (R_enable_despacho=1), the source resolves to Q = R_tag_despacho, overriding the stale Rs_Qi value.
- Destination: ADD/SUB/LD assert R_enable_despacho with R_target_despacho = Ri and R_tag_despacho = station tag. ST does not write register status.
- NOP accept: consumes the instruction; no enables; V/Q/A outputs hold.
- FSM:
  - RUN -> STALL when Instr_valid && !Instr_ready.
  - STALL -> RUN on accept, or when Instr_valid deasserts.
  - In STALL, Stall_count increments by 1 per cycle, saturating at all-ones; it never clears except on reset.
- A reset mid-issue discards the in-flight pulse; no enable is emitted after Reset_n is released until a new accept.

Optional Feature:
- Macro: DESPACHO_CDB_BYPASS_EN.
- When defined, a CDB_valid broadcast whose CDB_tag matches a source's resolved tag (including a bypass tag) in the accept cycle resolves that source to V = CDB_data, Q = 0.
- When undefined, the CDB inputs are ignored (left unconnected internally) and the tag is forwarded.

Test Plan:
- Reset: drive Reset_n low mid-cycle -> outputs go to reset values immediately and Stall_count=0.
- ADD R1,R2,R3 with R2, R3 free (data 5, 7) -> next cycle Enable_ADD=01, Vj=5, Vk=7, Qj=Qk=0, R_tag_despacho=1, Instr_ready was 1.
- Back-to-back: ADD R1,... then SUB R4,R1,R1 on consecutive cycles with Busy_ADD held at 00 -> second goes to station 1 (Enable_ADD=10), Qj=Qk=1.
- ADD stations full (Busy_ADD=11) with ADD valid for 3 cycles -> Instr_ready=0, FSM STALL, Stall_count=3. Then free station 0 -> accept, Enable_ADD=01.
- ST R5,0x12 with R5 tag 3 and Busy_LOAD=00 -> Enable_LOAD=01, A=0x12, Qk=3, R_enable_despacho=0.
- With DESPACHO_CDB_BYPASS_EN: LD dependency Rj tag 2 while CDB_valid, CDB_tag=2, CDB_data=0x0AAA -> Vj=0x0AAA, Qj=0. Without the macro -> Qj=2.
